// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam int         NUM_DIGITS  = 3;
    localparam int         SCRATCH_W   = BCD_DIGIT_W * NUM_DIGITS;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// One BCD digit correction step: digits of 5 or more get 3 added before the shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + ADD3_VAL : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one bit per clock, with registered
// digit outputs that only change on the done edge.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// SHIFT | one adjust-and-shift per clock, BIN_W clocks total
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hunds
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    generate
        if (BIN_W < 4 || BIN_W > 9) begin : g_bad_width
            $error("bin_to_bcd_seq: BIN_W must be in 4..9");
        end
    endgenerate

    state_t               r_state;
    logic [BIN_W-1:0]     r_shift;
    logic [SCRATCH_W-1:0] r_scratch;
    logic [CNT_W-1:0]     r_cnt;
    logic [SCRATCH_W-1:0] w_adj;
    logic [SCRATCH_W-1:0] w_next_scratch;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_next_scratch = {w_adj[SCRATCH_W-2:0], r_shift[BIN_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            hunds     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                        busy      <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= r_shift << 1;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    // Final bit: publish the post-shift digits on this same edge.
                    if (r_cnt == CNT_W'(1)) begin
                        ones    <= w_next_scratch[3:0];
                        tens    <= w_next_scratch[7:4];
                        hunds   <= w_next_scratch[11:8];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, handshake, abort and a full sweep.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy;
    logic             done;
    logic [3:0]       ones, tens, hunds;

    int n_checks = 0;
    int n_errors = 0;
    int held_h = 0, held_t = 0, held_o = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ones   (ones),
        .tens   (tens),
        .hunds  (hunds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion (possibly on a done cycle) and check latency, busy, digits.
    task automatic run_conv(input int v, input int pulse_at, input int pulse_v);
        int lat, busy_low, unstable, eh, et, eo;
        eh = v / 100;
        et = (v / 10) % 10;
        eo = v % 10;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        tick();
        start    = 1'b0;
        bin_in   = '0;
        lat      = 0;
        busy_low = 0;
        unstable = 0;
        do begin
            if (lat == pulse_at) begin
                start  = 1'b1;
                bin_in = BIN_W'(pulse_v);
            end
            tick();
            start = 1'b0;
            lat++;
            if (!done) begin
                if (!busy) busy_low++;
                if (hunds != held_h || tens != held_t || ones != held_o) unstable++;
            end
        end while (!done && lat < 20);
        chk($sformatf("latency[%0d]", v), lat, BIN_W);
        chk($sformatf("busy_held[%0d]", v), busy_low, 0);
        chk($sformatf("stable[%0d]", v), unstable, 0);
        chk($sformatf("busy_at_done[%0d]", v), int'(busy), 0);
        chk($sformatf("bcd[%0d]", v), int'({hunds, tens, ones}), (eh << 8) | (et << 4) | eo);
        chk($sformatf("digit_range[%0d]", v),
            int'(hunds <= 4'd9 && tens <= 4'd9 && ones <= 4'd9), 1);
        held_h = eh;
        held_t = et;
        held_o = eo;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    initial begin
        int nd;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_digits", int'({hunds, tens, ones}), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        run_conv(0, -1, 0);
        tick();
        chk("done_one_cycle_0", int'(done), 0);

        run_conv(255, -1, 0);
        tick();
        chk("done_one_cycle_255", int'(done), 0);

        // Second start lands on the done cycle of the first.
        run_conv(100, -1, 0);
        run_conv(99, -1, 0);
        tick();

        // Start pulsed mid-conversion must be ignored, not queued.
        run_conv(137, 2, 42);
        count_dones(12, nd);
        chk("no_extra_done", nd, 0);
        chk("held_after_ignore", int'({hunds, tens, ones}), 12'h137);

        // Abort by reset mid-conversion.
        start  = 1'b1;
        bin_in = BIN_W'(200);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_digits", int'({hunds, tens, ones}), 0);
        tick();
        rst_n = 1'b1;
        held_h = 0;
        held_t = 0;
        held_o = 0;
        count_dones(12, nd);
        chk("no_done_after_abort", nd, 0);
        chk("digits_after_abort", int'({hunds, tens, ones}), 0);
        run_conv(200, -1, 0);

        // Back-to-back sweep of every input value.
        for (int v = 0; v < (1 << BIN_W); v++) run_conv(v, -1, 0);
        tick();
        chk("final_idle_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
